dmem_line_responder: RTL and testbench
======================================

Name: dmem_line_responder

Overview:
- Responder end of the data-cache-to-memory line interface: a 256-bit-line backing data memory.
- Accepts line read and line write requests from the data cache controller and completes each after a fixed latency with a one-cycle acknowledge.
- Holds read data stable after the acknowledge so the cache can fill its SRAM one cycle later.
- Sits directly below the data cache in the CPU memory hierarchy.

Parameters:
LATENCY, 10, cycles from request acceptance to ack (legal range 2..255)
LINE_ADDR_W, 9, line index width; memory holds 2^LINE_ADDR_W lines of 256 bits (default 16 KiB)

Ports:
clk_i  input  1  system clock, rising edge
rst_i  input  1  asynchronous active-low reset
addr_i  input  32  byte address; bits [4:0] ignored, line index = addr_i[5 +: LINE_ADDR_W], higher bits ignored (aliasing)
data_i  input  256  write line data
enable_i  input  1  request valid; held high by initiator until ack
write_i  input  1  1 = line write, 0 = line read; qualified by enable_i
ack_o  output  1  one-cycle completion pulse
data_o  output  256  read line data, registered

Behaviour:
- Reset (rst_i low, async):
  - state IDLE, latency counter 0, ack_o 0, data_o 0.
  - Captured addr, data and write-flag registers cleared.
  - Memory array is not reset.
- States: IDLE, BUSY, ACK.
- IDLE:
  - On a rising edge with enable_i=1: capture line index, write_i and data_i (write data is captured here, not later), clear counter, go to BUSY.
  - Otherwise remain in IDLE.
- BUSY:
  - Counter increments each cycle.
  - When counter == LATENCY-2: go to ACK. For writes, commit the captured data to the array at that edge. For reads, load data_o from the array at that edge.
  - Result: ack_o is high in exactly the LATENCY-th cycle after the acceptance edge.
- ACK:
  - ack_o=1 for this single cycle; next state IDLE unconditionally.
  - ACK does not accept a new request, even if enable_i is high.
- Back-to-back requests: the initiator may keep enable_i high after ack with write_i and addr_i changed (writeback followed by refill). IDLE samples this in the cycle after ACK and accepts it as a new request. Minimum spacing between acks is LATENCY+1 cycles.
- data_o hold rule:
  - data_o changes only on the edge entering ACK for a read.
  - It holds through the ack cycle, all following cycles, and any intervening write, until the next read's ACK entry.
  - The initiator writes its SRAM from data_o in the cycle after ack.
- enable_i dropping during BUSY is a protocol violation. The request still completes, ack is issued, and a write is still committed.
- addr_i, data_i and write_i changing during BUSY have no effect (captured copies are used).
- Reset mid-request: abort immediately, ack_o 0. A write whose commit edge has not occurred is not performed. A read leaves data_o at 0.
- Same-line write then read: the read returns the newly written data.
- Byte offset bits never affect behaviour.

Test Plan:
- Reset, then hold enable_i=0 for 20 cycles -> ack_o stays 0, data_o == 0.
- Write line 0xA5A5...A5 to addr 0x0000_0040, enable accepted at cycle 0 -> ack_o high only in cycle 10 (LATENCY=10). Then read addr 0x0000_005C -> ack at read-acceptance+10, data_o == 0xA5A5...A5 and unchanged 5 cycles after ack.
- Writeback/refill sequence: write 0x1111...1 to 0x0000_0400, keep enable_i high after ack, switch write_i=0, addr 0x0000_0800 (previously written 0x2222...2) -> second ack exactly 11 cycles after the first, data_o == 0x2222...2.
- Write 0xDEAD...BEEF to 0x0000_0020 while changing data_i to 0 and addr_i to 0x40 from the cycle after acceptance -> reading 0x0000_0020 returns 0xDEAD...BEEF; line 0x40 unchanged.
- Aliasing: write 0x3333...3 to 0x0000_4020 (LINE_ADDR_W=9), read 0x0000_0020 -> 0x3333...3.
- Reset asserted at cycle 5 of a write of 0x7777...7 to 0x60 (line previously 0x1234...) -> ack_o never pulses; after release, reading 0x60 returns 0x1234....

Source files
------------

// File: rtl/dmem_line_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_line_responder
// Purpose  : Line-granular backing data memory answering the data cache.
//            Each accepted read/write completes after a fixed LATENCY with a
//            single-cycle ack; read data is registered and held until the
//            next read completes.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_line_responder #(
  parameter int LATENCY     = 10,  // acceptance edge to ack cycle, 2..255
  parameter int LINE_ADDR_W = 9    // 2^LINE_ADDR_W lines of 256 bits
) (
  input  logic         clk_i,
  input  logic         rst_i,      // asynchronous, active low
  input  logic [31:0]  addr_i,
  input  logic [255:0] data_i,
  input  logic         enable_i,
  input  logic         write_i,
  output logic         ack_o,
  output logic [255:0] data_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  // Counter value at which BUSY hands over to ACK; the acceptance edge and
  // the ACK-entry edge together account for the other two cycles.
  localparam logic [7:0] c_LAST_CNT = 8'(LATENCY - 2);

  state_t                   r_state;
  logic [7:0]               r_cnt;
  logic [LINE_ADDR_W-1:0]   r_line;
  logic [255:0]             r_data;
  logic                     r_write;
  logic [255:0]             r_mem [0:(1<<LINE_ADDR_W)-1];

  logic w_commit;
  logic w_unused_addr;

  // Offset bits and the aliased upper address bits carry no meaning here.
  assign w_unused_addr = ^{addr_i[4:0], addr_i[31:5+LINE_ADDR_W]};

  // A captured write lands in the array on the same edge that enters ACK.
  assign w_commit = (r_state == S_BUSY) && (r_cnt == c_LAST_CNT) && r_write;

  // Backing array write port; contents deliberately survive reset.
  always_ff @(posedge clk_i) begin
    if (w_commit) begin
      r_mem[r_line] <= r_data;
    end
  end

  // Request FSM: capture on acceptance, count latency, pulse ack, load reads.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_line  <= '0;
      r_data  <= '0;
      r_write <= 1'b0;
      ack_o   <= 1'b0;
      data_o  <= '0;
    end else begin
      ack_o <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (enable_i) begin
            // Everything the request needs is sampled now; later input
            // changes are ignored until the next acceptance.
            r_line  <= addr_i[5 +: LINE_ADDR_W];
            r_write <= write_i;
            r_data  <= data_i;
            r_cnt   <= '0;
            r_state <= S_BUSY;
          end
        end
        S_BUSY: begin
          r_cnt <= r_cnt + 8'd1;
          if (r_cnt == c_LAST_CNT) begin
            r_state <= S_ACK;
            ack_o   <= 1'b1;
            if (!r_write) begin
              data_o <= r_mem[r_line];
            end
          end
        end
        S_ACK: begin
          // No acceptance here, so back-to-back requests get a gap cycle.
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_line_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_line_responder
// Purpose  : Self-checking bench for dmem_line_responder: directed vector
//            table, reset corner cases and a randomized run against a
//            line-array reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_line_responder;

  localparam int LATENCY     = 10;
  localparam int LINE_ADDR_W = 9;
  localparam int NLINES      = 1 << LINE_ADDR_W;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic [31:0]  addr_i;
  logic [255:0] data_i;
  logic         enable_i;
  logic         write_i;
  logic         ack_o;
  logic [255:0] data_o;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  // Reference model: the line array and the last completed read.
  logic [255:0] mdl_mem [NLINES];
  logic [255:0] mdl_rd;

  typedef struct {
    logic         wr;
    logic [31:0]  addr;
    logic [255:0] data;
    logic         keep;   // leave enable_i high after ack
    logic         scram;  // disturb inputs while the request is in flight
    logic [255:0] exp;    // data_o expected at ack
  } vec_t;

  vec_t vecs [12];

  dmem_line_responder #(
    .LATENCY     (LATENCY),
    .LINE_ADDR_W (LINE_ADDR_W)
  ) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .addr_i   (addr_i),
    .data_i   (data_i),
    .enable_i (enable_i),
    .write_i  (write_i),
    .ack_o    (ack_o),
    .data_o   (data_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc = cyc + 1;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic int line_of(input logic [31:0] a);
    return int'((a / 32) % NLINES);
  endfunction

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [31:0] addr_for(input int line);
    logic [31:0] a;
    a = $urandom;
    a = (a & ~32'h0000_3FE0) | (32'(line) << 5);
    return a;
  endfunction

  // Issue one request; call #1 after a posedge with the DUT idle.
  task automatic do_req(input logic wr, input logic [31:0] addr, input logic [255:0] data,
                        input logic keep, input logic scram, input logic [255:0] exp,
                        output int ack_c);
    int  n;
    bit  got;
    write_i  = wr;
    addr_i   = addr;
    data_i   = data;
    enable_i = 1'b1;
    n   = 0;
    got = 0;
    ack_c = -1;
    while (!got && n < 40) begin
      @(negedge clk_i);
      n++;
      if (ack_o) begin
        got   = 1;
        ack_c = cyc;
      end else if (scram && n >= 2) begin
        addr_i   = 32'h0000_0040;
        data_i   = '0;
        write_i  = ~wr;
        enable_i = 1'($urandom);
      end
    end
    // One idle cycle precedes acceptance, then LATENCY cycles to the ack.
    chk("ack_latency", 256'(n), 256'(LATENCY + 1));
    chk("data_at_ack", data_o, exp);
    if (wr) mdl_mem[line_of(addr)] = data;
    else    mdl_rd = mdl_mem[line_of(addr)];
    @(posedge clk_i);
    #1;
    if (!keep || !got) enable_i = 1'b0;
  endtask

  initial begin
    int ack_c;
    int prev_ack;
    logic prev_keep;
    logic [255:0] exp;
    logic wr;
    logic [31:0] a;
    logic [255:0] d;
    int ln;

    vecs[0]  = '{1'b1, 32'h0000_0040, {32{8'hA5}},       1'b0, 1'b0, 256'h0};
    vecs[1]  = '{1'b0, 32'h0000_005C, 256'h0,            1'b0, 1'b0, {32{8'hA5}}};
    vecs[2]  = '{1'b1, 32'h0000_0800, {64{4'h2}},        1'b0, 1'b0, {32{8'hA5}}};
    vecs[3]  = '{1'b1, 32'h0000_0400, {64{4'h1}},        1'b1, 1'b0, {32{8'hA5}}};
    vecs[4]  = '{1'b0, 32'h0000_0800, 256'h0,            1'b0, 1'b0, {64{4'h2}}};
    vecs[5]  = '{1'b1, 32'h0000_0020, {8{32'hDEADBEEF}}, 1'b0, 1'b1, {64{4'h2}}};
    vecs[6]  = '{1'b0, 32'h0000_0020, 256'h0,            1'b0, 1'b0, {8{32'hDEADBEEF}}};
    vecs[7]  = '{1'b0, 32'h0000_0040, 256'h0,            1'b0, 1'b0, {32{8'hA5}}};
    vecs[8]  = '{1'b1, 32'h0000_4020, {64{4'h3}},        1'b0, 1'b0, {32{8'hA5}}};
    vecs[9]  = '{1'b0, 32'h0000_0020, 256'h0,            1'b0, 1'b0, {64{4'h3}}};
    vecs[10] = '{1'b1, 32'h0000_0060, {16{16'h1234}},    1'b0, 1'b0, {64{4'h3}}};
    vecs[11] = '{1'b0, 32'h0000_041F, 256'h0,            1'b0, 1'b0, {64{4'h1}}};

    mdl_rd   = '0;
    rst_i    = 1'b0;
    enable_i = 1'b0;
    write_i  = 1'b0;
    addr_i   = '0;
    data_i   = '0;
    repeat (3) @(negedge clk_i);
    rst_i = 1'b1;

    // Quiet interface after reset.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      chk("idle_ack", 256'(ack_o), 256'h0);
      chk("idle_data", data_o, 256'h0);
    end
    @(posedge clk_i);
    #1;

    // Directed vector table.
    prev_ack  = -1;
    prev_keep = 1'b0;
    for (int i = 0; i < 12; i++) begin
      do_req(vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].keep, vecs[i].scram,
             vecs[i].exp, ack_c);
      if (prev_keep) chk("b2b_spacing", 256'(ack_c - prev_ack), 256'(LATENCY + 1));
      prev_ack  = ack_c;
      prev_keep = vecs[i].keep;
      if (!vecs[i].wr && !vecs[i].keep) begin
        for (int k = 0; k < 5; k++) begin
          @(negedge clk_i);
          chk("hold_ack", 256'(ack_o), 256'h0);
          chk("hold_data", data_o, vecs[i].exp);
        end
        @(posedge clk_i);
        #1;
      end
    end

    // Reset in the middle of a write to line 0x60.
    write_i  = 1'b1;
    addr_i   = 32'h0000_0060;
    data_i   = {32{8'h77}};
    enable_i = 1'b1;
    @(negedge clk_i);
    for (int n = 2; n <= 6; n++) begin
      @(negedge clk_i);
      chk("pre_rst_ack", 256'(ack_o), 256'h0);
    end
    rst_i    = 1'b0;
    enable_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      chk("rst_ack", 256'(ack_o), 256'h0);
      chk("rst_data", data_o, 256'h0);
    end
    rst_i  = 1'b1;
    mdl_rd = '0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk_i);
      chk("post_rst_ack", 256'(ack_o), 256'h0);
    end
    @(posedge clk_i);
    #1;
    do_req(1'b0, 32'h0000_0060, 256'h0, 1'b0, 1'b0, {16{16'h1234}}, ack_c);

    // Randomized traffic over 16 lines with aliased/offset addresses.
    for (int l = 0; l < 16; l++) begin
      do_req(1'b1, addr_for(l), rnd256(), 1'b0, 1'b0, mdl_rd, ack_c);
    end
    for (int i = 0; i < 40; i++) begin
      wr  = 1'($urandom);
      ln  = int'($urandom_range(0, 15));
      a   = addr_for(ln);
      d   = rnd256();
      exp = wr ? mdl_rd : mdl_mem[ln];
      do_req(wr, a, d, 1'($urandom), 1'($urandom), exp, ack_c);
    end
    enable_i = 1'b0;
    repeat (2) @(negedge clk_i);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire
